// File: rtl/control_sequencer_if.sv
// Control sequencer bus bundle: instruction opcode and divider status in,
// datapath strobes, one-hot ALU op, divider start and run flag out.
//   master: sequencer side (drives strobes, receives opcode/div_done)
//   slave : datapath side (drives opcode/div_done, receives strobes)
interface control_sequencer_if;
    logic [4:0]  opcode;
    logic        div_done;
    logic        PCout, Zlowout, Zhighout, MDRout;
    logic        MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        IncPC, Read;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [12:0] alu_op;
    logic        div_rst;
    logic        run;

    modport master (
        input  opcode, div_done,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        output alu_op, div_rst, run
    );

    modport slave (
        output opcode, div_done,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        input  alu_op, div_rst, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer for the single-bus datapath: fetch (T0-T2), then
// opcode-specific execute steps, a bounded divider wait and a halt state.
//   clk : clock, all state changes on the rising edge
//   clr : synchronous active-high reset
//   bus : control_sequencer_if.master (opcode/div_done in, strobes out)
module control_sequencer #(
    parameter int unsigned DIV_TIMEOUT = 63
) (
    input  logic                 clk,
    input  logic                 clr,
    control_sequencer_if.master  bus
);

    localparam int unsigned ALU_W = 13;
    // Counter holds 0..DIV_TIMEOUT-1 before the abort fires.
    localparam int unsigned CNT_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [ALU_W-1:0] ALU_DIV = ALU_W'(13'h0020);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DIV_WAIT, S_HALT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ALU_W-1:0]   alu_sel;
    logic               is_bin, is_un, is_mul, is_div, is_mfx, is_halt;

    // Opcode classification; unlisted codes fall through as nop.
    always_comb begin
        alu_sel = '0;
        is_bin  = 1'b0;
        is_un   = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mfx  = 1'b0;
        is_halt = 1'b0;
        unique case (bus.opcode)
            OP_AND:  begin alu_sel = ALU_W'(13'h0001); is_bin = 1'b1; end
            OP_OR:   begin alu_sel = ALU_W'(13'h0002); is_bin = 1'b1; end
            OP_ADD:  begin alu_sel = ALU_W'(13'h0004); is_bin = 1'b1; end
            OP_SUB:  begin alu_sel = ALU_W'(13'h0008); is_bin = 1'b1; end
            OP_SHR:  begin alu_sel = ALU_W'(13'h0040); is_bin = 1'b1; end
            OP_SHL:  begin alu_sel = ALU_W'(13'h0080); is_bin = 1'b1; end
            OP_ROR:  begin alu_sel = ALU_W'(13'h0100); is_bin = 1'b1; end
            OP_ROL:  begin alu_sel = ALU_W'(13'h0200); is_bin = 1'b1; end
            OP_SHRA: begin alu_sel = ALU_W'(13'h1000); is_bin = 1'b1; end
            OP_MUL:  begin alu_sel = ALU_W'(13'h0010); is_mul = 1'b1; end
            OP_DIV:  begin alu_sel = ALU_DIV;          is_div = 1'b1; end
            OP_NEG:  begin alu_sel = ALU_W'(13'h0400); is_un  = 1'b1; end
            OP_NOT:  begin alu_sel = ALU_W'(13'h0800); is_un  = 1'b1; end
            OP_MFHI, OP_MFLO: is_mfx  = 1'b1;
            OP_HALT:          is_halt = 1'b1;
            default: ;
        endcase
    end

    // Next state and divider wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = S_T2;
            S_T2:  state_d = S_T3;
            S_T3: begin
                if (is_bin || is_un || is_mul || is_div) state_d = S_T4;
                else if (is_halt)                        state_d = S_HALT;
                else                                     state_d = S_T0;
            end
            // Divide always visits DIV_WAIT, even if div_done is already high.
            S_T4: state_d = is_div ? S_DIV_WAIT : S_T5;
            S_T5: state_d = (is_mul || is_div) ? S_T6 : S_T0;
            S_T6: state_d = S_T0;
            S_DIV_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.div_done)                              state_d = S_T5;
                else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1))     state_d = S_T0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic pc_out, zlow_out, zhigh_out, mdr_out;
    logic mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic inc_pc, read, gra, grb, grc, r_in, r_out, div_rst, run;
    logic [ALU_W-1:0] alu_op;

    // Moore output decode from the registered state and the current IR opcode.
    always_comb begin
        pc_out = 1'b0; zlow_out = 1'b0; zhigh_out = 1'b0; mdr_out = 1'b0;
        mar_in = 1'b0; mdr_in = 1'b0; ir_in = 1'b0; y_in = 1'b0;
        z_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
        inc_pc = 1'b0; read = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0;
        div_rst = 1'b0;
        alu_op  = '0;
        run     = (state_q != S_RST) && (state_q != S_HALT);
        unique case (state_q)
            S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; end
            S_T1: begin read = 1'b1; mdr_in = 1'b1; end
            S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
            S_T3: begin
                if (is_bin || is_mul || is_div) begin
                    grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
                end
                div_rst = is_div;
                if (is_mfx) begin
                    gra = 1'b1; r_in = 1'b1;
                end
            end
            S_T4: begin
                if (is_bin || is_mul || is_div) begin
                    grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_sel;
                end else if (is_un) begin
                    grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_sel;
                end
            end
            S_DIV_WAIT: begin
                grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = ALU_DIV;
            end
            S_T5: begin
                zlow_out = 1'b1;
                if (is_mul || is_div) lo_in = 1'b1;
                else begin
                    gra = 1'b1; r_in = 1'b1;
                end
            end
            S_T6: begin zhigh_out = 1'b1; hi_in = 1'b1; end
            default: ;
        endcase
    end

    assign bus.PCout    = pc_out;
    assign bus.Zlowout  = zlow_out;
    assign bus.Zhighout = zhigh_out;
    assign bus.MDRout   = mdr_out;
    assign bus.MARin    = mar_in;
    assign bus.MDRin    = mdr_in;
    assign bus.IRin     = ir_in;
    assign bus.Yin      = y_in;
    assign bus.Zin      = z_in;
    assign bus.HIin     = hi_in;
    assign bus.LOin     = lo_in;
    assign bus.IncPC    = inc_pc;
    assign bus.Read     = read;
    assign bus.Gra      = gra;
    assign bus.Grb      = grb;
    assign bus.Grc      = grc;
    assign bus.Rin      = r_in;
    assign bus.Rout     = r_out;
    assign bus.alu_op   = alu_op;
    assign bus.div_rst  = div_rst;
    assign bus.run      = run;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: builds the expected per-cycle strobe sequence
// of each instruction from the opcode table and compares it every cycle.
module tb_control_sequencer;

    localparam int unsigned TO = 63;

    // Packed view of all outputs, one bit per strobe.
    localparam logic [32:0] PCOUT  = 33'd1 << 0;
    localparam logic [32:0] ZLOW   = 33'd1 << 1;
    localparam logic [32:0] ZHIGH  = 33'd1 << 2;
    localparam logic [32:0] MDROUT = 33'd1 << 3;
    localparam logic [32:0] MARIN  = 33'd1 << 4;
    localparam logic [32:0] MDRIN  = 33'd1 << 5;
    localparam logic [32:0] IRIN   = 33'd1 << 6;
    localparam logic [32:0] YIN    = 33'd1 << 7;
    localparam logic [32:0] ZIN    = 33'd1 << 8;
    localparam logic [32:0] HIIN   = 33'd1 << 9;
    localparam logic [32:0] LOIN   = 33'd1 << 10;
    localparam logic [32:0] INCPC  = 33'd1 << 11;
    localparam logic [32:0] READ   = 33'd1 << 12;
    localparam logic [32:0] GRA    = 33'd1 << 13;
    localparam logic [32:0] GRB    = 33'd1 << 14;
    localparam logic [32:0] GRC    = 33'd1 << 15;
    localparam logic [32:0] RIN    = 33'd1 << 16;
    localparam logic [32:0] ROUT   = 33'd1 << 17;
    localparam int          ALU0   = 18;
    localparam logic [32:0] DIVRST = 33'd1 << 31;
    localparam logic [32:0] RUN    = 33'd1 << 32;

    localparam logic [32:0] V_T0 = RUN | PCOUT | MARIN | INCPC;
    localparam logic [32:0] V_T1 = RUN | READ | MDRIN;
    localparam logic [32:0] V_T2 = RUN | MDROUT | IRIN;

    localparam logic [4:0] OP_ADD = 5'b00011, OP_MUL = 5'b01111, OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NOP = 5'b11010, OP_HALT = 5'b11011;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    control_sequencer_if bus ();

    control_sequencer #(.DIV_TIMEOUT(TO)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0] exp_q[$];

    function automatic logic [32:0] obs_vec();
        logic [32:0] v;
        v = '0;
        v[0]  = bus.PCout;  v[1]  = bus.Zlowout; v[2]  = bus.Zhighout; v[3] = bus.MDRout;
        v[4]  = bus.MARin;  v[5]  = bus.MDRin;   v[6]  = bus.IRin;     v[7] = bus.Yin;
        v[8]  = bus.Zin;    v[9]  = bus.HIin;    v[10] = bus.LOin;
        v[11] = bus.IncPC;  v[12] = bus.Read;
        v[13] = bus.Gra;    v[14] = bus.Grb;     v[15] = bus.Grc;
        v[16] = bus.Rin;    v[17] = bus.Rout;
        v[30:18] = bus.alu_op;
        v[31] = bus.div_rst;
        v[32] = bus.run;
        return v;
    endfunction

    // Instruction class: 0 nop, 1 binary, 2 unary, 3 mul, 4 div, 5 mfhi/mflo, 6 halt.
    function automatic int op_class(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: return 1;
            5'b10001, 5'b10010:                     return 2;
            5'b01111:                               return 3;
            5'b10000:                               return 4;
            5'b11000, 5'b11001:                     return 5;
            5'b11011:                               return 6;
            default:                                return 0;
        endcase
    endfunction

    function automatic logic [32:0] alu_mask(input logic [4:0] op);
        int b;
        case (op)
            5'b00101: b = 0;  5'b00110: b = 1;  5'b00011: b = 2;  5'b00100: b = 3;
            5'b01111: b = 4;  5'b10000: b = 5;  5'b00111: b = 6;  5'b01001: b = 7;
            5'b01010: b = 8;  5'b01011: b = 9;  5'b10001: b = 10; 5'b10010: b = 11;
            5'b01000: b = 12;
            default:  b = -1;
        endcase
        return (b < 0) ? 33'd0 : (33'd1 << (ALU0 + b));
    endfunction

    // Reference sequence; k = wait cycle in which div_done rises (0: already in T4).
    task automatic build(input logic [4:0] op, input int k);
        logic [32:0] alu;
        int nwait;
        alu = alu_mask(op);
        exp_q.delete();
        exp_q.push_back(V_T0); exp_q.push_back(V_T1); exp_q.push_back(V_T2);
        case (op_class(op))
            1: begin
                exp_q.push_back(RUN | GRB | ROUT | YIN);
                exp_q.push_back(RUN | GRC | ROUT | ZIN | alu);
                exp_q.push_back(RUN | ZLOW | GRA | RIN);
            end
            2: begin
                exp_q.push_back(RUN);
                exp_q.push_back(RUN | GRB | ROUT | ZIN | alu);
                exp_q.push_back(RUN | ZLOW | GRA | RIN);
            end
            3: begin
                exp_q.push_back(RUN | GRB | ROUT | YIN);
                exp_q.push_back(RUN | GRC | ROUT | ZIN | alu);
                exp_q.push_back(RUN | ZLOW | LOIN);
                exp_q.push_back(RUN | ZHIGH | HIIN);
            end
            4: begin
                exp_q.push_back(RUN | GRB | ROUT | YIN | DIVRST);
                exp_q.push_back(RUN | GRC | ROUT | ZIN | alu);
                nwait = (k == 0) ? 1 : ((k <= int'(TO)) ? k : int'(TO));
                for (int w = 0; w < nwait; w++) exp_q.push_back(RUN | GRC | ROUT | ZIN | alu);
                if (k <= int'(TO)) begin
                    exp_q.push_back(RUN | ZLOW | LOIN);
                    exp_q.push_back(RUN | ZHIGH | HIIN);
                end
            end
            5: exp_q.push_back(RUN | GRA | RIN);
            default: exp_q.push_back(RUN);
        endcase
    endtask

    // Runs one instruction from T0 (optionally only the first `limit` cycles).
    task automatic run_instr(input logic [4:0] op, input int k, input int limit, input string name);
        int n;
        logic [32:0] o;
        build(op, k);
        n = (limit > 0 && limit < exp_q.size()) ? limit : exp_q.size();
        for (int i = 0; i < n; i++) begin
            bus.opcode = (i < 3) ? 5'($urandom) : op;
            if (op_class(op) != 4 || i < 4) bus.div_done = 1'($urandom);
            else if (k == 0)                bus.div_done = (i == 4 || i == 5);
            else                            bus.div_done = (i == 4 + k);
            @(negedge clk);
            o = obs_vec();
            n_checks++;
            if (o !== exp_q[i])
                $display("FAIL %s op=%b cyc=%0d: got %h expected %h", name, op, i, o, exp_q[i]);
            else
                n_pass++;
            @(posedge clk); #1;
        end
        bus.div_done = 1'b0;
    endtask

    task automatic check_idle(input string name, input int cyc);
        logic [32:0] o;
        @(negedge clk);
        o = obs_vec();
        n_checks++;
        if (o !== 33'd0) $display("FAIL %s cyc=%0d: got %h expected 0", name, cyc, o);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.opcode = 5'($urandom);
        bus.div_done = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) check_idle("reset_hold", i);
        clr = 1'b0;
        check_idle("reset_release", 0);
    endtask

    task automatic test_add();  run_instr(OP_ADD, 0, 0, "add");  endtask
    task automatic test_mul();  run_instr(OP_MUL, 0, 0, "mul");  endtask

    task automatic test_div();
        run_instr(OP_DIV, 10, 0, "div_done10");
        run_instr(OP_DIV, 0, 0, "div_done_early");
        run_instr(OP_DIV, int'(TO), 0, "div_done_last");
    endtask

    task automatic test_div_timeout();
        run_instr(OP_DIV, 1000, 0, "div_timeout");
        run_instr(OP_ADD, 0, 0, "after_timeout");
    endtask

    task automatic test_halt();
        run_instr(OP_HALT, 0, 0, "halt");
        for (int i = 0; i < 20; i++) begin
            bus.opcode = 5'($urandom);
            bus.div_done = 1'($urandom);
            check_idle("halted", i);
        end
        clr = 1'b1;
        check_idle("halt_clr", 0);
        clr = 1'b0;
        check_idle("halt_release", 0);
        run_instr(OP_ADD, 0, 0, "restart_add");
    endtask

    task automatic test_clr_in_div();
        logic [32:0] o;
        run_instr(OP_DIV, 1000, 8, "clr_div_pre");
        clr = 1'b1;
        @(negedge clk);
        o = obs_vec();
        n_checks++;
        if (o !== (RUN | GRC | ROUT | ZIN | (33'd1 << (ALU0 + 5))))
            $display("FAIL clr_div_wait: got %h expected %h", o, RUN | GRC | ROUT | ZIN | (33'd1 << (ALU0 + 5)));
        else n_pass++;
        @(posedge clk); #1;
        clr = 1'b0;
        check_idle("clr_div_rst", 0);
        // Full timeout afterwards shows the wait counter restarted from zero.
        run_instr(OP_DIV, 1000, 0, "div_after_clr");
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom);
            if (op == OP_HALT) op = OP_NOP;
            run_instr(op, int'($urandom_range(0, 70)), 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_instr(5'b10001, 0, 0, "b2b_neg");
        run_instr(5'b11000, 0, 0, "b2b_mfhi");
        run_instr(5'b00000, 0, 0, "b2b_undef");
        run_instr(OP_DIV, 3, 0, "b2b_div");
        run_instr(5'b11001, 0, 0, "b2b_mflo");
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_div_timeout();
        test_back_to_back();
        test_clr_in_div();
        test_random();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have ports: clr  in  1  synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have ports: opcode  in  5  IR[31:27] from the datapath instruction register.
REQ-004 SHALL have ports: div_done  in  1  divider result valid in Z.
REQ-005 SHALL have ports: PCout, Zlowout, Zhighout, MDRout  out  1 each  bus source enables.
REQ-006 SHALL have ports: MARin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load enables.
REQ-007 SHALL have ports: IncPC, Read  out  1 each  PC increment and memory-read strobe.
REQ-008 SHALL have ports: Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and general-register in/out strobes for the select/encode logic.
REQ-009 SHALL have ports: alu_op  out  13  one-hot ALU op: bit0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHL, 8 ROR, 9 ROL, 10 NEG, 11 NOT, 12 SHRA.
REQ-010 SHALL have ports: div_rst  out  1  divider start/clear pulse; run  out  1  high while executing.
REQ-011 SHALL have parameter: DIV_TIMEOUT, default 63, maximum cycles in DIV_WAIT before abort.

Function
REQ-012 SHALL implement states RST, T0, T1, T2, T3, T4, T5, T6, DIV_WAIT, HALT in a registered state register; outputs SHALL be decoded from state and opcode only (Moore).
REQ-013 Opcodes: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol, 01111 mul, 10000 div, 10001 neg, 10010 not, 11000 mfhi, 11001 mflo, 11010 nop, 11011 halt; every other code SHALL execute as nop.
REQ-014 Fetch: T0 = PCout, MARin, IncPC; T1 = Read, MDRin; T2 = MDRout, IRin; every state SHALL last one cycle except DIV_WAIT and HALT.
REQ-015 Opcode SHALL be sampled in T3 onward only; T0-T2 outputs SHALL be opcode-independent.
REQ-016 Binary ALU ops (add..rol): T3 = Grb, Rout, Yin; T4 = Grc, Rout, matching alu_op bit, Zin; T5 = Zlowout, Gra, Rin; then T0.
REQ-017 Unary ops (neg, not): T3 = no strobes; T4 = Grb, Rout, alu_op bit, Zin; T5 = Zlowout, Gra, Rin; then T0.
REQ-018 mul: T3 = Grb, Rout, Yin; T4 = Grc, Rout, alu_op[4], Zin; T5 = Zlowout, LOin; T6 = Zhighout, HIin; then T0.
REQ-019 div: T3 = Grb, Rout, Yin, div_rst; T4 = Grc, Rout, alu_op[5], Zin, then DIV_WAIT; DIV_WAIT holds Grc, Rout, alu_op[5], Zin until div_done; then T5 = Zlowout, LOin; T6 = Zhighout, HIin; then T0.
REQ-020 div_done sampled high in T4 SHALL still pass through DIV_WAIT for exactly one cycle.
REQ-021 DIV_WAIT SHALL count cycles from 0; on reaching DIV_TIMEOUT without div_done SHALL go to T0 with no HI/LO write.
REQ-022 mfhi/mflo: T3 = Gra, Rin, plus HI/LO source selection left to select logic; transition T0 after T3.
REQ-023 nop: T3 no strobes, then T0; halt: T3 to HALT; HALT SHALL assert no strobes and run=0 until clr.
REQ-024 alu_op SHALL be all-zero outside T4/DIV_WAIT; at most one bus source enable SHALL be high in any cycle.

Reset
REQ-025 clr high at a rising edge SHALL force state RST and clear the DIV_WAIT counter regardless of current state, including mid-divide and HALT.
REQ-026 In RST all outputs SHALL be 0 and run=0; first cycle with clr low SHALL enter T0 on the next edge with run=1.

Verification
REQ-027 clr for 2 cycles, release -> all outputs 0 during clr; T0 strobes (PCout, MARin, IncPC) appear exactly one cycle after release.
REQ-028 opcode=00011 (add) -> 6 cycles T0..T5; alu_op=13'h004 with Zin only in T4; Zlowout+Gra+Rin in T5; next cycle T0.
REQ-029 opcode=01111 (mul) -> LOin in T5, HIin in T6, 7 cycles total, alu_op=13'h010 in T4.
REQ-030 opcode=10000 (div), div_done high 10 cycles after T4 -> div_rst pulse in T3 only; Zin held every wait cycle; LOin/HIin in the two cycles after div_done.
REQ-031 opcode=10000, div_done never asserted, DIV_TIMEOUT=63 -> return to T0 after 63 wait cycles, HIin/LOin never asserted.
REQ-032 opcode=11011 (halt) -> run drops after T3 and stays 0 for 20 cycles; clr then restarts at T0; clr asserted in DIV_WAIT -> RST next edge, all outputs 0.
